// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin write arbiter in front of a register file.
// Define REGARB_INIT_EN to clear registers 0..INIT_CYCLES-1 after reset.
module regfile_wr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int INIT_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [5*NUM_REQ-1:0]  req_addr,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  wr_hold,
  output logic                  regwrite,
  output logic [4:0]            writereg,
  output logic [31:0]           writedata,
  output logic                  init_done
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic {INIT, RUN} state_t;
`ifdef REGARB_INIT_EN
  localparam state_t RST_STATE = INIT;
`else
  localparam state_t RST_STATE = RUN;
`endif
  state_t state, state_nx;
  logic [4:0] cnt;
  logic [PW-1:0] rr_ptr, gidx;
  logic [NUM_REQ-1:0] grant;
  logic found, accept, last;
  logic [4:0] gaddr;
  logic [31:0] gdata;
  assign last = cnt == 5'(INIT_CYCLES-1);
  always_comb begin
    state_nx = state;
    if (state == INIT && last) state_nx = RUN;
  end
  always_comb begin
    grant = '0;
    gidx = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++)
      if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        gidx = PW'((int'(rr_ptr) + k) % NUM_REQ);
        grant[(int'(rr_ptr) + k) % NUM_REQ] = 1'b1;
      end
  end
  assign gaddr = req_addr[5*int'(gidx) +: 5];
  assign gdata = req_data[32*int'(gidx) +: 32];
  assign accept = rst && state == RUN && !wr_hold && found;
  assign req_ready = accept ? grant : '0;
  always_ff @(posedge clk)
    if (!rst) begin
      state <= RST_STATE;
      cnt <= '0;
      rr_ptr <= '0;
      regwrite <= 1'b0;
      writereg <= '0;
      writedata <= '0;
      init_done <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == INIT) begin
        regwrite <= 1'b1;
        writereg <= cnt;
        writedata <= '0;
        cnt <= cnt + 1'b1;
        init_done <= last;
      end else begin
        // x0 is hardwired: accept the transfer but never write it
        regwrite <= accept && gaddr != '0;
        init_done <= 1'b1;
        if (accept) begin
          writereg <= gaddr;
          writedata <= gdata;
          rr_ptr <= (gidx == PW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed scoreboard bench for regfile_wr_arbiter (NUM_REQ=3).
module tb_regfile_wr_arbiter;
  logic clk = 1'b0;
  logic rst, wr_hold, regwrite, init_done;
  logic [2:0] req_valid, req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [4:0] writereg;
  logic [31:0] writedata;
  int checks = 0, fails = 0;
  typedef struct packed {logic we; logic [4:0] r; logic [31:0] d;} exp_t;
  exp_t sbq[$];
  int m_ptr;

  regfile_wr_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .wr_hold(wr_hold),
    .regwrite(regwrite), .writereg(writereg), .writedata(writedata),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[i*5 +: 5] = a;
    req_data[i*32 +: 32] = d;
  endtask

  // one arbitration cycle: predict grant, push expected write, compare after the edge
  task automatic step(input logic [2:0] v, input logic hold, input string tag);
    logic [2:0] exp_rdy;
    int g;
    exp_t e;
    req_valid = v;
    wr_hold = hold;
    exp_rdy = '0;
    g = -1;
    if (!hold)
      for (int k = 0; k < 3; k++)
        if (g < 0 && v[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
    if (g >= 0) exp_rdy[g] = 1'b1;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
    if (g >= 0) begin
      e.r = req_addr[g*5 +: 5];
      e.d = req_data[g*32 +: 32];
      e.we = e.r != 5'd0;
      m_ptr = (g + 1) % 3;
    end else begin
      e = '0;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({tag, ".regwrite"}, 32'(regwrite), 32'(e.we));
    if (e.we) begin
      chk({tag, ".writereg"}, 32'(writereg), 32'(e.r));
      chk({tag, ".writedata"}, writedata, e.d);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    wr_hold = 1'b0;
    req_valid = 3'b111;
    set_req(0, 5'd1, 32'h11);
    set_req(1, 5'd2, 32'h22);
    set_req(2, 5'd3, 32'h33);
    @(negedge clk);
    chk("rst.ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst.regwrite", 32'(regwrite), 32'd0);
    chk("rst.writereg", 32'(writereg), 32'd0);
    chk("rst.writedata", writedata, 32'd0);
    chk("rst.init_done", 32'(init_done), 32'd0);
    rst = 1'b1;
    req_valid = 3'b000;
    m_ptr = 0;
  endtask

`ifdef REGARB_INIT_EN
  task automatic run_init(input int n);
    req_valid = 3'b111;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("init.ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("init.regwrite", 32'(regwrite), 32'd1);
      chk("init.writereg", 32'(writereg), 32'(i));
      chk("init.writedata", writedata, 32'd0);
      chk("init.init_done", 32'(init_done), 32'(i == 31));
    end
    req_valid = 3'b000;
  endtask
`else
  task automatic run_init(input int n);
    req_valid = 3'b000;
    @(posedge clk);
    #1;
    chk("noinit.init_done", 32'(init_done), 32'd1);
    chk("noinit.regwrite", 32'(regwrite), 32'd0);
    if (n > 0) begin
      @(posedge clk);
      #1;
      chk("noinit.regwrite2", 32'(regwrite), 32'd0);
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    wr_hold = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    m_ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    run_init(32);
    set_req(0, 5'd5, 32'hA);
    set_req(1, 5'd6, 32'hB);
    set_req(2, 5'd7, 32'hC);
    for (int i = 0; i < 6; i++) step(3'b111, 1'b0, "rr_all");
    set_req(2, 5'd9, 32'h1234);
    step(3'b100, 1'b0, "only2");
    step(3'b011, 1'b0, "ptr_after2");
    set_req(0, 5'd0, 32'hFFFF);
    m_ptr = 1;
    step(3'b001, 1'b0, "x0");
    set_req(0, 5'd5, 32'hA);
    step(3'b111, 1'b0, "pre_hold");
    wr_hold = 1'b1;
    #1;
    chk("hold_keeps_write", 32'(regwrite), 32'd1);
    for (int i = 0; i < 4; i++) step(3'b111, 1'b1, "hold");
    for (int i = 0; i < 3; i++) step(3'b111, 1'b0, "resume");
    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < 3; j++) set_req(j, 5'($urandom_range(0, 31)), $urandom);
      step(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), "rand");
    end
    do_reset();
    run_init(10);
    do_reset();
    run_init(32);
    step(3'b010, 1'b0, "post_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, giving the number of write requesters (legal 2..4).
REQ-002 The block SHALL have parameter INIT_CYCLES, default 32, giving the number of registers cleared by the init sequence.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset sampled on rising clk.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ bits: bit i high means requester i holds a pending write.
REQ-006 The block SHALL have port req_addr, input, 5*NUM_REQ bits: requester i target register index in bits [5i+4:5i].
REQ-007 The block SHALL have port req_data, input, 32*NUM_REQ bits: requester i write data in bits [32i+31:32i].
REQ-008 The block SHALL have port req_ready, output, NUM_REQ bits: one-hot grant; a transfer occurs on a cycle where req_valid[i] and req_ready[i] are both high.
REQ-009 The block SHALL have port wr_hold, input, 1 bit: while high, no grant is issued.
REQ-010 The block SHALL have port regwrite, output, 1 bit: register-file write enable.
REQ-011 The block SHALL have port writereg, output, 5 bits: register-file write index.
REQ-012 The block SHALL have port writedata, output, 32 bits: register-file write data.
REQ-013 The block SHALL have port init_done, output, 1 bit: high once the block is in RUN.

Function
REQ-014 State machine SHALL have two states: INIT (clearing registers) and RUN (arbitrating).
REQ-015 In INIT, req_ready SHALL be all-zero, and on each cycle the block SHALL drive regwrite=1, writedata=0 and writereg=init counter, with the counter running 0..INIT_CYCLES-1.
REQ-016 After the write of index INIT_CYCLES-1, the next state SHALL be RUN and init_done SHALL go high on that same edge.
REQ-017 In RUN, req_ready SHALL be combinational: at most one bit high, and no bit high when wr_hold=1 or req_valid=0.
REQ-018 Arbitration SHALL be round-robin. Search starts at pointer rr_ptr and proceeds upward modulo NUM_REQ; the first valid requester found is granted.
REQ-019 On a grant to requester i, rr_ptr SHALL become (i+1) mod NUM_REQ at the next edge; with no grant, rr_ptr SHALL hold.
REQ-020 Outputs regwrite, writereg and writedata SHALL be registered with latency 1. The edge that accepts requester i SHALL load regwrite=1 and the granted address and data.
REQ-021 regwrite SHALL be 0 in RUN cycles following an edge with no accepted transfer; writereg and writedata SHALL hold their last values.
REQ-022 A transfer addressed to register 0 SHALL be accepted (ready high) with regwrite forced to 0, so x0 is never written in RUN.
REQ-023 Requesters SHALL hold valid, addr and data stable until accepted. The block SHALL not depend on data of non-granted requesters.
REQ-024 wr_hold rising SHALL NOT cancel a write already registered on the output; it SHALL only block new grants.
REQ-025 Sustained throughput SHALL be one write per cycle. With all requesters valid, each SHALL be granted once every NUM_REQ cycles.

Reset
REQ-026 While rst=0 at a rising edge, the block SHALL set state=INIT, init counter=0, rr_ptr=0, regwrite=0, writereg=0, writedata=0, init_done=0.
REQ-027 req_ready SHALL be all-zero while rst=0. Reset asserted mid-INIT or mid-RUN SHALL discard the in-flight write and restart INIT.

Configuration
REQ-028 Macro REGARB_INIT_EN SHALL select the init sequence. When defined, INIT behaves per REQ-015/016. When undefined, reset leaves the state in RUN, init_done=1 from the first edge after reset release, and no clearing writes are issued.

Verification
REQ-029 Release reset with REGARB_INIT_EN defined -> 32 consecutive cycles of regwrite=1, writereg=0..31, writedata=0; init_done rises after index 31; req_ready=0 throughout.
REQ-030 In RUN, all three valid with addr 5/6/7 and data 0xA/0xB/0xC -> writes in order 5,6,7,5,... one per cycle, each one cycle after its grant.
REQ-031 Only requester 2 valid (addr 9, data 0x1234) with rr_ptr=0 -> req_ready=3'b100 the same cycle; next cycle regwrite=1, writereg=9, writedata=0x1234; rr_ptr=0.
REQ-032 Requester 0 valid with addr 0, data 0xFFFF -> req_ready[0]=1; next cycle regwrite=0.
REQ-033 wr_hold=1 with all requesters valid for 4 cycles -> req_ready=0 and regwrite=0 after the first cycle; releasing hold resumes from the unchanged rr_ptr.
REQ-034 Assert rst=0 for one edge at INIT counter 10 -> counter restarts at 0 and init_done stays 0; with macro undefined, init_done=1 and no zero-writes occur.
